// File: rtl/add_feeder.sv
// Operand feeder for the matched-operand accumulator: queues operands, issues only shadow-matching ones.
// Optional macro ADD_FEEDER_ZERO_DROP_EN: zero-valued pushes are discarded and counted as drops.
// state | meaning
// IDLE  | waiting for a queued operand with stall low
// ISSUE | head equals shadow; drive it onto add, then pop and advance shadow
// DROP  | head mismatches; pop and count it
module add_feeder #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int INIT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         stall,
  output logic [W-1:0] add,
  output logic [W-1:0] shadow,
  output logic [3:0]   drop_cnt,
  output logic         z_full,
  output logic         z_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [W-1:0] INIT_V   = W'(INIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  head;
  logic          push, wr, pop, zero_push;
  logic [1:0]    drop_inc;
  logic [4:0]    drop_sum;
  logic [3:0]    drop_nxt;

  assign z_full   = (count == FULL_CNT);
  assign in_ready = !z_full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign pop      = (state == ISSUE) || (state == DROP);

`ifdef ADD_FEEDER_ZERO_DROP_EN
  assign zero_push = push && (in_data == '0);
`else
  assign zero_push = 1'b0;
`endif
  assign wr = push && !zero_push;

  // A zero push and a DROP in the same cycle both count.
  assign drop_inc = {1'b0, state == DROP} + {1'b0, zero_push};
  assign drop_sum = {1'b0, drop_cnt} + {3'b000, drop_inc};
  assign drop_nxt = (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
        if (count != '0 && !stall)
          state_nxt = (head == shadow) ? ISSUE : DROP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outside ISSUE, add is the inverse of shadow so the accumulator never matches.
  assign add   = (state == ISSUE) ? head : ~shadow;
  assign z_err = ((state == ISSUE) && (add != shadow)) ||
                 ((state != ISSUE) && (add == shadow));

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      shadow   <= INIT_V;
      drop_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == ISSUE) shadow <= shadow + head;
    end
  end
endmodule

// File: tb/tb_add_feeder.sv
// Directed bench for add_feeder (W=2, DEPTH=4, INIT=1); honours ADD_FEEDER_ZERO_DROP_EN.
module tb_add_feeder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'd0;
  logic       stall = 1'b0;
  logic       in_ready, z_full, z_err;
  logic [1:0] add, shadow;
  logic [3:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  add_feeder #(.W(2), .DEPTH(4), .INIT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall(stall), .add(add), .shadow(shadow),
    .drop_cnt(drop_cnt), .z_full(z_full), .z_err(z_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       do_reset;
    logic       valid;
    logic [1:0] data;
    logic       stl;
    logic [1:0] e_add;
    logic [1:0] e_shadow;
    logic [3:0] e_drop;
    logic       e_full;
    logic       e_ready;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // z_err must stay low on every cycle outside reset.
  always @(negedge clk) begin
    if (reset) check("z_err", {3'b0, z_err}, 4'd0);
  end

  task automatic do_reset();
    in_valid = 1'b0; in_data = 2'd0; stall = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_add", {2'b0, add}, 4'd2);
    check("rst_shadow", {2'b0, shadow}, 4'd1);
    check("rst_drop", drop_cnt, 4'd0);
    check("rst_ready", {3'b0, in_ready}, 4'd1);
    check("rst_full", {3'b0, z_full}, 4'd0);
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic s);
    in_valid = v; in_data = d; stall = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst,v,d,stall | add,shadow,drop,full,ready
    vecs[0]  = '{1'b1,1'b1,2'd1,1'b0, 2'd2,2'd1,4'd0,1'b0,1'b1};
    vecs[1]  = '{1'b0,1'b1,2'd2,1'b0, 2'd1,2'd1,4'd0,1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,2'd0,1'b1, 2'd1,2'd2,4'd0,1'b0,1'b1};
    vecs[3]  = '{1'b0,1'b0,2'd0,1'b0, 2'd2,2'd2,4'd0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b0,2'd0,1'b0, 2'd3,2'd0,4'd0,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b1,2'd3,1'b0, 2'd3,2'd0,4'd0,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,2'd0,1'b0, 2'd3,2'd0,4'd0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b0,2'd0,1'b0, 2'd3,2'd0,4'd1,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,2'd0,1'b0, 2'd3,2'd0,4'd1,1'b0,1'b1};
    vecs[9]  = '{1'b1,1'b1,2'd1,1'b1, 2'd2,2'd1,4'd0,1'b0,1'b1};
    vecs[10] = '{1'b0,1'b1,2'd3,1'b1, 2'd2,2'd1,4'd0,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b1,2'd3,1'b1, 2'd2,2'd1,4'd0,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b1,2'd3,1'b1, 2'd2,2'd1,4'd0,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b1,2'd2,1'b1, 2'd2,2'd1,4'd0,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd1,4'd0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd0,1'b0,1'b1};
    vecs[16] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd0,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd1,1'b0,1'b1};
    vecs[18] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd1,1'b0,1'b1};
    vecs[19] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd2,1'b0,1'b1};
    vecs[20] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd2,1'b0,1'b1};
    vecs[21] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd3,1'b0,1'b1};
    vecs[22] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd3,1'b0,1'b1};
    vecs[23] = '{1'b0,1'b0,2'd0,1'b0, 2'd1,2'd2,4'd3,1'b0,1'b1};

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].do_reset) do_reset();
      step(vecs[i].valid, vecs[i].data, vecs[i].stl);
      check($sformatf("v%0d_add", i), {2'b0, add}, {2'b0, vecs[i].e_add});
      check($sformatf("v%0d_shadow", i), {2'b0, shadow}, {2'b0, vecs[i].e_shadow});
      check($sformatf("v%0d_drop", i), drop_cnt, vecs[i].e_drop);
      check($sformatf("v%0d_full", i), {3'b0, z_full}, {3'b0, vecs[i].e_full});
      check($sformatf("v%0d_ready", i), {3'b0, in_ready}, {3'b0, vecs[i].e_ready});
    end

    // Drop counter saturation: 20 mismatching operands against shadow=1.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'd3, 1'b0);
      step(1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b0);
    end
    check("sat_drop", drop_cnt, 4'd15);
    check("sat_shadow", {2'b0, shadow}, 4'd1);

    // Asynchronous reset in the middle of an ISSUE cycle.
    do_reset();
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    check("pre_drop", drop_cnt, 4'd1);
    step(1'b0, 2'd0, 1'b0);
    check("issue_add", {2'b0, add}, 4'd1);
    #3 reset = 1'b0;
    #1;
    check("async_add", {2'b0, add}, 4'd2);
    check("async_shadow", {2'b0, shadow}, 4'd1);
    check("async_drop", drop_cnt, 4'd0);
    check("async_ready", {3'b0, in_ready}, 4'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step(1'b0, 2'd0, 1'b0);
    check("post_rst_add", {2'b0, add}, 4'd2);
    check("post_rst_shadow", {2'b0, shadow}, 4'd1);

    // Zero operand with shadow=1.
    do_reset();
    step(1'b1, 2'd0, 1'b0);
`ifdef ADD_FEEDER_ZERO_DROP_EN
    check("zero_drop_now", drop_cnt, 4'd1);
    check("zero_ready", {3'b0, in_ready}, 4'd1);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    check("zero_drop_after", drop_cnt, 4'd1);
    check("zero_add", {2'b0, add}, 4'd2);
`else
    check("zero_drop_now", drop_cnt, 4'd0);
    step(1'b0, 2'd0, 1'b0);
    check("zero_in_drop_add", {2'b0, add}, 4'd2);
    step(1'b0, 2'd0, 1'b0);
    check("zero_drop_after", drop_cnt, 4'd1);
    check("zero_shadow", {2'b0, shadow}, 4'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/add_feeder.md
Name: add_feeder

Overview:
- Upstream operand stage for the matched-operand accumulator, which adds `add` to its 2-bit state `x` only when `add == x`.
- Buffers incoming operands in a small FIFO and keeps a shadow copy of the downstream `x`.
- Issues an operand only when it equals the shadow, so every issued operand is consumed; all other operands are dropped and counted.
- Outside an issue cycle, `add` is held at the bitwise inverse of the shadow, so the downstream block never sees a spurious match.

Parameters:
- W, 2: operand width; equals the downstream `x` width.
- DEPTH, 4: FIFO depth in entries; power of 2, at least 2.
- INIT, 1: shadow reset value; equals the downstream `x` reset value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  operand offered.
- in_data  input  W  operand value.
- in_ready  output  1  FIFO can accept; equals !z_full.
- stall  input  1  downstream hold; while high, no ISSUE or DROP starts.
- add  output  W  operand to the downstream accumulator.
- shadow  output  W  tracked copy of downstream `x`.
- drop_cnt  output  4  count of dropped operands, saturating.
- z_full  output  1  FIFO full.
- z_err  output  1  property flag; must never assert.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-operation):
  - FIFO empty; state IDLE; shadow=INIT; add=~INIT; drop_cnt=0; z_full=0; in_ready=1; z_err=0.
- Push: in_valid && in_ready at a clock edge writes in_data at the tail.
  - in_valid while full is ignored; no overwrite.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- FSM states: IDLE, ISSUE, DROP. Each state lasts exactly one cycle except IDLE.
  - IDLE: add=~shadow. If FIFO non-empty and stall=0, go to ISSUE when head==shadow, otherwise to DROP. Else remain in IDLE.
  - ISSUE: add=head. At the end of the cycle, pop, set shadow <= shadow+head (mod 2^W, carry discarded), go to IDLE.
  - DROP: add=~shadow. At the end of the cycle, pop, set drop_cnt <= min(drop_cnt+1, 15), go to IDLE.
- Throughput and latency:
  - At most one operand retired per 2 cycles.
  - An operand pushed at edge n into an empty FIFO, with stall=0, reaches ISSUE or DROP during cycle n+2, i.e. the cycle after edge n+1.
- stall: sampled only in IDLE; an ISSUE or DROP already in progress completes.
- z_err = (state==ISSUE && add!=shadow) || (state!=ISSUE && add==shadow). Combinational; intended as the model-checking property.
- Wrap-around:
  - FIFO pointers are log2(DEPTH) bits and wrap.
  - Occupancy count is log2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.

Optional Feature:
- Macro: ADD_FEEDER_ZERO_DROP_EN.
- Defined: an accepted push with in_data==0 is not written to the FIFO and increments drop_cnt (saturating) at that edge. in_ready is unchanged.
  - Same-cycle push-zero and DROP: drop_cnt increments by 2, saturating at 15.
- Not defined: zero operands are queued and handled like any other operand; zero matches only when shadow==0.

Test Plan (W=2, DEPTH=4, INIT=1):
- Reset release with no input -> add=2'b10, shadow=1, in_ready=1, drop_cnt=0, z_err=0 on every cycle.
- Push 1, then push 2 -> ISSUE with add=1, shadow becomes 2; then ISSUE with add=2, shadow becomes 0 (wrap). add never equals shadow outside ISSUE.
- With shadow=1, push 3 -> DROP: drop_cnt=1, shadow stays 1, add never equals 3.
- stall=1, push 1,3,3,3 -> z_full=1, in_ready=0; a fifth push of 2 is ignored. Release stall -> ISSUE(1), then three DROPs; drop_cnt=3; final shadow=2.
- Assert reset low mid-ISSUE, asynchronously between edges -> add=2'b10 and shadow=1 immediately; FIFO empty, drop_cnt=0.
- 20 mismatching operands -> drop_cnt saturates at 15. With ADD_FEEDER_ZERO_DROP_EN defined, push 0 -> FIFO occupancy unchanged, drop_cnt increments.
